// File: rtl/memory_stage_ctrl.sv
// rtl/memory_stage_ctrl.sv - memory stage: data-memory req/ack handshake, upstream stall, MEM/WB register
// A memory access holds the pipeline from its IDLE cycle through its last REQ cycle.
module memory_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              wbs_in,
  input  logic [1:0]        mm_in,
  input  logic              wm_in,
  input  logic              ni_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid_out,
  output logic              wb_wbs_out,
  output logic              wb_ni_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              err_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              wbs_q, wbs_d;
  logic              ni_q, ni_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wbs_q, wb_wbs_d;
  logic              wb_ni_q, wb_ni_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic              access;

  // A store takes priority over a load when both are flagged.
  assign access = valid_in & (wm_in | (mm_in == 2'b01));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_d      = alu_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    wbs_d      = wbs_q;
    ni_d       = ni_q;
    err_d      = err_q;
    wb_valid_d = 1'b0;
    wb_wbs_d   = 1'b0;
    wb_ni_d    = 1'b0;
    wb_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          alu_d   = alu_result_in;
          wdata_d = mem_data_in;
          we_d    = wm_in;
          wbs_d   = wbs_in;
          ni_d    = ni_in;
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          wb_valid_d = valid_in;
          wb_wbs_d   = wbs_in;
          wb_ni_d    = ni_in;
          wb_data_d  = (mm_in == 2'b10) ? mem_data_in : alu_result_in;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          wb_valid_d = 1'b1;
          wb_wbs_d   = wbs_q;
          wb_ni_d    = ni_q;
          wb_data_d  = we_q ? alu_q : mem_rdata;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: retire the op anyway so the pipeline cannot deadlock.
          wb_valid_d = 1'b1;
          wb_wbs_d   = wbs_q;
          wb_ni_d    = ni_q;
          wb_data_d  = we_q ? alu_q : '0;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wbs_q      <= 1'b0;
      ni_q       <= 1'b0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_wbs_q   <= 1'b0;
      wb_ni_q    <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_q      <= alu_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wbs_q      <= wbs_d;
      ni_q       <= ni_d;
      err_q      <= err_d;
      wb_valid_q <= wb_valid_d;
      wb_wbs_q   <= wb_wbs_d;
      wb_ni_q    <= wb_ni_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // stall is gated by rst_n so it drops during reset even with an access presented.
  assign stall        = rst_n & (((state_q == S_IDLE) & access) | (state_q == S_REQ));
  assign mem_req      = (state_q == S_REQ);
  assign mem_we       = we_q;
  assign mem_addr     = alu_q[ADDR_W-1:0];
  assign mem_wdata    = wdata_q;
  assign wb_valid_out = wb_valid_q;
  assign wb_wbs_out   = wb_wbs_q;
  assign wb_ni_out    = wb_ni_q;
  assign wb_data_out  = wb_data_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// tb/tb_memory_stage_ctrl.sv - randomized self-checking bench for memory_stage_ctrl
module tb_memory_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, wbs_in, wm_in, ni_in, mem_ack;
  logic [1:0]  mm_in;
  logic [15:0] alu_result_in, mem_data_in, mem_rdata;
  logic        stall, mem_req, mem_we, wb_valid_out, wb_wbs_out, wb_ni_out, err_out;
  logic [15:0] mem_addr, mem_wdata, wb_data_out;

  int checks = 0;
  int failures = 0;
  logic exp_err = 1'b0;

  memory_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .wbs_in(wbs_in), .mm_in(mm_in),
    .wm_in(wm_in), .ni_in(ni_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid_out(wb_valid_out), .wb_wbs_out(wb_wbs_out), .wb_ni_out(wb_ni_out),
    .wb_data_out(wb_data_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction in EX/MEM, starting just after a rising edge. ack_cyc: REQ cycle index
  // (0-based) on which mem_ack is raised; any value >= TO means the memory never answers.
  task automatic do_instr(input logic v, input logic wbs, input logic [1:0] mm, input logic wm,
                          input logic ni, input logic [15:0] alu, input logic [15:0] md,
                          input int ack_cyc);
    logic        acc, fin, got_ack;
    logic [15:0] rd, exp_data;
    valid_in = v; wbs_in = wbs; mm_in = mm; wm_in = wm; ni_in = ni;
    alu_result_in = alu; mem_data_in = md;
    mem_ack = 1'($urandom);
    mem_rdata = 16'($urandom);
    acc = v && (wm || mm == 2'b01);
    if (!acc) begin
      @(negedge clk);
      check("alu_stall", stall, 0);
      check("alu_req", mem_req, 0);
      @(posedge clk); #1;
      check("alu_wb_valid", wb_valid_out, v);
      check("alu_wbs", wb_wbs_out, wbs);
      check("alu_ni", wb_ni_out, ni);
      if (v) check("alu_wb_data", wb_data_out, (mm == 2'b10) ? md : alu);
      check("alu_err", err_out, exp_err);
      mem_ack = 1'b0;
      return;
    end
    @(negedge clk);
    check("idle_stall", stall, 1);
    check("idle_req", mem_req, 0);
    @(posedge clk); #1;
    check("idle_bubble", wb_valid_out, 0);
    fin = 1'b0; got_ack = 1'b0; rd = '0;
    for (int k = 0; k < TO && !fin; k++) begin
      mem_ack = (k == ack_cyc);
      rd = 16'($urandom);
      mem_rdata = rd;
      @(negedge clk);
      check("req_req", mem_req, 1);
      check("req_stall", stall, 1);
      check("req_addr", mem_addr, alu);
      check("req_we", mem_we, wm);
      if (wm) check("req_wdata", mem_wdata, md);
      @(posedge clk); #1;
      if (k == ack_cyc) begin
        fin = 1'b1; got_ack = 1'b1;
      end else if (k == TO - 1) begin
        fin = 1'b1;
      end else begin
        check("req_bubble", wb_valid_out, 0);
      end
    end
    if (!got_ack) exp_err = 1'b1;
    exp_data = wm ? alu : (got_ack ? rd : 16'h0000);
    check("mem_wb_valid", wb_valid_out, 1);
    check("mem_wb_data", wb_data_out, exp_data);
    check("mem_wbs", wb_wbs_out, wbs);
    check("mem_ni", wb_ni_out, ni);
    check("mem_err", err_out, exp_err);
    mem_ack = 1'($urandom);
    @(negedge clk);
    check("done_stall", stall, 0);
    check("done_req", mem_req, 0);
    @(posedge clk); #1;
    check("done_bubble", wb_valid_out, 0);
    check("done_err", err_out, exp_err);
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; wbs_in = 1'b0; mm_in = 2'b00; wm_in = 1'b0; ni_in = 1'b0;
    alu_result_in = '0; mem_data_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_wb_valid", wb_valid_out, 0);
    check("rst_wb_data", wb_data_out, 0);
    check("rst_err", err_out, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_instr(1, 1, 2'b00, 0, 1, 16'h1234, 16'h0000, 99);
    do_instr(1, 1, 2'b00, 1, 0, 16'h0040, 16'hBEEF, 1);
    do_instr(1, 1, 2'b01, 0, 1, 16'h0010, 16'h0000, 0);
    do_instr(1, 0, 2'b10, 0, 1, 16'h5555, 16'hCAFE, 99);
    do_instr(1, 1, 2'b01, 0, 0, 16'h0022, 16'h0000, 3);
    do_instr(1, 1, 2'b01, 1, 1, 16'h0077, 16'h1111, 2);
    do_instr(0, 1, 2'b01, 1, 1, 16'h0088, 16'h2222, 0);
    do_instr(1, 1, 2'b01, 0, 0, 16'h0033, 16'h0000, 99);

    // Reset in the middle of a REQ with the access still presented.
    valid_in = 1'b1; mm_in = 2'b01; wm_in = 1'b0; alu_result_in = 16'h0099; mem_ack = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", mem_req, 0);
    check("midrst_stall", stall, 0);
    check("midrst_wb_valid", wb_valid_out, 0);
    check("midrst_err", err_out, 0);
    exp_err = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_instr(1, 1, 2'b00, 0, 0, 16'hABCD, 16'h0000, 99);

    for (int i = 0; i < 250; i++) begin
      do_instr($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
               $urandom_range(0, 2) == 0, 1'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end
endmodule
